// File: rtl/pe_psum_collector.sv
// pe_psum_collector
// Receive side of the PE interface: takes partial sums from the PE over a
// valid/ready handshake, buffers them in a first-word-fall-through FIFO and
// forwards them downstream. Each tile ends with a last flag and a done pulse.
// Optional build macro PSUM_RELU_EN: negative psums are written into the FIFO
// as zero instead of bit-exact.

module pe_psum_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CNT_WIDTH-1:0]        tile_len,
    input  logic [DATA_WIDTH-1:0]       psum_data_P2M,
    input  logic                        psum_valid_P2M,
    output logic                        psum_ready_M2P,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done,
    output logic                        drop_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_WIDTH + 1;
    localparam logic [LW-1:0]        LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]        LEVEL_ONE  = LW'(1);
    localparam logic [AW-1:0]        PTR_ONE    = AW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  drop_err_q, drop_err_d;
    logic [EW-1:0]         mem_q [FIFO_DEPTH];

    logic                  accept;
    logic                  pop;
    logic                  last_in;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [EW-1:0]         head;

    // Handshake and output view, all derived from registered state so the PE never sees a combinational loop
    assign psum_ready_M2P = (state_q == COLLECT) && (level_q < LEVEL_FULL);
    assign accept         = psum_valid_P2M && psum_ready_M2P;
    assign out_valid      = (level_q != '0);
    assign pop            = out_valid && out_ready;
    assign head           = mem_q[rd_ptr_q];
    assign out_data       = out_valid ? head[DATA_WIDTH-1:0] : '0;
    assign out_last       = out_valid && head[EW-1];
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign drop_err       = drop_err_q;
    assign fifo_level     = level_q;
    assign last_in        = (remaining_q == CNT_ONE);

    // Value written into the FIFO; the optional clamp sits here so it costs no extra cycle
    always_comb begin
`ifdef PSUM_RELU_EN
        wr_data = psum_data_P2M[DATA_WIDTH-1] ? '0 : psum_data_P2M;
`else
        wr_data = psum_data_P2M;
`endif
    end

    // Next-state logic for the tile FSM, the FIFO pointers/level and the drop pulse
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        drop_err_d  = (state_q == IDLE) && psum_valid_P2M;

        case (state_q)
            IDLE: begin
                if (start && (tile_len != '0)) begin
                    state_d     = COLLECT;
                    remaining_d = tile_len;
                end
            end
            COLLECT: begin
                if (accept) begin
                    remaining_d = remaining_q - CNT_ONE;
                    if (last_in) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (accept && !pop) begin
            level_d = level_q + LEVEL_ONE;
        end else if (!accept && pop) begin
            level_d = level_q - LEVEL_ONE;
        end
    end

    // Control registers; reset abandons any open tile and empties the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            drop_err_q  <= drop_err_d;
        end
    end

    // FIFO payload storage; stale contents are harmless because the output is masked when empty
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= {last_in, wr_data};
        end
    end

endmodule

// File: tb/tb_pe_psum_collector.sv
// tb_pe_psum_collector
// Directed bench for pe_psum_collector. Stimulus pushes the hand-computed
// expected {last, data} of every accepted psum into a queue; an independent
// monitor pops and compares on every output handshake.
// Honours PSUM_RELU_EN the same way as the design build.

module tb_pe_psum_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  tile_len;
    logic [15:0] psum_data_P2M;
    logic        psum_valid_P2M;
    logic        psum_ready_M2P;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        drop_err;
    logic [3:0]  fifo_level;

    logic [16:0] expQ [$];
    logic [16:0] monEntry;
    int          total    = 0;
    int          bad      = 0;
    int          accCount = 0;

`ifdef PSUM_RELU_EN
    localparam logic [15:0] EXP_NEG = 16'h0000;
`else
    localparam logic [15:0] EXP_NEG = 16'hFFFB;
`endif

    pe_psum_collector #(
        .DATA_WIDTH(16),
        .FIFO_DEPTH(8),
        .CNT_WIDTH (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .tile_len      (tile_len),
        .psum_data_P2M (psum_data_P2M),
        .psum_valid_P2M(psum_valid_P2M),
        .psum_ready_M2P(psum_ready_M2P),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done),
        .drop_err      (drop_err),
        .fifo_level    (fifo_level)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got timeout/none, expected event", name);
    endtask

    // Called at posedge+1; pulses start for one cycle
    task automatic startTile(input logic [7:0] len);
        start    = 1'b1;
        tile_len = len;
        @(posedge clk);
        #1;
        start    = 1'b0;
        tile_len = 8'd0;
    endtask

    // Offers one psum and holds it until accepted (bounded); records the expected output
    task automatic applyStimulus(input logic [15:0] data, input logic [15:0] expData, input logic expLast);
        bit got = 1'b0;
        int waitCnt = 0;
        psum_data_P2M  = data;
        psum_valid_P2M = 1'b1;
        while (!got && waitCnt < 100) begin
            @(negedge clk);
            if (psum_ready_M2P === 1'b1) begin
                got = 1'b1;
                expQ.push_back({expLast, expData});
            end
            @(posedge clk);
            #1;
            waitCnt++;
        end
        psum_valid_P2M = 1'b0;
        if (got) accCount++;
        else failNow("accept_timeout");
    endtask

    // Waits (bounded) for done, then checks busy is high with done and drops one cycle later
    task automatic waitDone(input string name);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            n++;
        end
        if (!seen) begin
            failNow({name, "_done_timeout"});
        end else begin
            checkOutput({name, "_busy_in_done"}, busy, 1);
            @(negedge clk);
            checkOutput({name, "_done_pulse_end"}, done, 0);
            checkOutput({name, "_busy_after_done"}, busy, 0);
        end
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every output handshake is compared against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_output: got 0x%0h, expected no output", out_data);
                end else begin
                    monEntry = expQ.pop_front();
                    checkOutput("out_data", out_data, monEntry[15:0]);
                    checkOutput("out_last", out_last, monEntry[16]);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        failNow("global_timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Main directed sequence
    initial begin
        rst            = 1'b1;
        start          = 1'($urandom_range(0, 1));
        tile_len       = 8'($urandom);
        psum_data_P2M  = 16'($urandom);
        psum_valid_P2M = 1'($urandom_range(0, 1));
        out_ready      = 1'($urandom_range(0, 1));

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_ready", psum_ready_M2P, 0);
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_out_last", out_last, 0);
            checkOutput("rst_out_data", out_data, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_drop_err", drop_err, 0);
            checkOutput("rst_fifo_level", fifo_level, 0);
            @(posedge clk);
            #1;
            if (i == 2) begin
                rst            = 1'b0;
                start          = 1'b0;
                tile_len       = 8'd0;
                psum_data_P2M  = 16'd0;
                psum_valid_P2M = 1'b0;
                out_ready      = 1'b0;
            end else begin
                start          = 1'($urandom_range(0, 1));
                tile_len       = 8'($urandom);
                psum_data_P2M  = 16'($urandom);
                psum_valid_P2M = 1'($urandom_range(0, 1));
                out_ready      = 1'($urandom_range(0, 1));
            end
        end

        // Basic tile of four back-to-back psums
        $display("[TB] basic tile");
        out_ready = 1'b1;
        startTile(8'd4);
        checkOutput("basic_busy", busy, 1);
        fork
            begin
                applyStimulus(16'h0001, 16'h0001, 1'b0);
                applyStimulus(16'h0002, 16'h0002, 1'b0);
                applyStimulus(16'h0003, 16'h0003, 1'b0);
                applyStimulus(16'h0004, 16'h0004, 1'b1);
            end
            begin
                int n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!(psum_valid_P2M === 1'b1 && psum_ready_M2P === 1'b1) && n < 20);
                @(negedge clk);
                checkOutput("first_latency_valid", out_valid, 1);
                checkOutput("first_latency_data", out_data, 16'h0001);
            end
        join
        @(negedge clk);
        checkOutput("basic_last_visible", out_last, 1);
        checkOutput("basic_done_early", done, 0);
        @(posedge clk);
        #1;
        waitDone("basic");

        // Backpressure, full FIFO stall and pointer wrap
        $display("[TB] backpressure and wrap");
        out_ready = 1'b0;
        accCount  = 0;
        startTile(8'd12);
        fork
            begin
                for (int i = 1; i <= 12; i++) begin
                    applyStimulus(16'h0100 + 16'(i), 16'h0100 + 16'(i), (i == 12));
                end
            end
            begin
                repeat (20) @(negedge clk);
                checkOutput("bp_accepted", accCount, 8);
                checkOutput("bp_level_full", fifo_level, 8);
                checkOutput("bp_ready_low", psum_ready_M2P, 0);
                checkOutput("bp_pe_stalled", psum_valid_P2M, 1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDone("bp");
        checkOutput("bp_all_accepted", accCount, 12);
        checkOutput("bp_level_empty", fifo_level, 0);

        // Psum offered while idle is dropped
        $display("[TB] idle drop");
        psum_data_P2M  = 16'h00AA;
        psum_valid_P2M = 1'b1;
        @(posedge clk);
        #1;
        psum_valid_P2M = 1'b0;
        @(negedge clk);
        checkOutput("drop_err_pulse", drop_err, 1);
        checkOutput("drop_level", fifo_level, 0);
        checkOutput("drop_out_valid", out_valid, 0);
        @(negedge clk);
        checkOutput("drop_err_clear", drop_err, 0);
        @(posedge clk);
        #1;
        startTile(8'd0);
        @(negedge clk);
        checkOutput("zero_len_busy", busy, 0);
        checkOutput("zero_len_ready", psum_ready_M2P, 0);
        @(posedge clk);
        #1;

        // Reset in the middle of a tile
        $display("[TB] reset mid-tile");
        out_ready = 1'b0;
        startTile(8'd6);
        applyStimulus(16'h0031, 16'h0031, 1'b0);
        applyStimulus(16'h0032, 16'h0032, 1'b0);
        applyStimulus(16'h0033, 16'h0033, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_level", fifo_level, 0);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_ready", psum_ready_M2P, 0);
        @(negedge clk);
        checkOutput("midrst_no_done", done, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        startTile(8'd2);
        applyStimulus(16'h0011, 16'h0011, 1'b0);
        applyStimulus(16'h0022, 16'h0022, 1'b1);
        waitDone("after_rst");

        // Negative psum handling
        $display("[TB] negative psum");
        startTile(8'd2);
        applyStimulus(16'hFFFB, EXP_NEG, 1'b0);
        applyStimulus(16'h0007, 16'h0007, 1'b1);
        waitDone("feature");

        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_psum_collector.md
Name: pe_psum_collector

Overview:
- Receive-side counterpart of the PE input driver. Sits on the P2M path of PE_IF and consumes partial sums (psum_data_P2M) produced by SV_PE.
- Uses a valid/ready handshake with the PE and buffers results in a small first-word-fall-through FIFO.
- Forwards results on an output stream, framed per tile with a last flag and a done pulse.

Parameters:
- DATA_WIDTH, 16, psum width (two's complement).
- FIFO_DEPTH, 8, buffer entries; power of 2, at least 2.
- CNT_WIDTH, 8, width of tile length and counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a tile.
- tile_len  in  CNT_WIDTH  number of psums expected in the tile; sampled when start is high.
- psum_data_P2M  in  DATA_WIDTH  psum from the PE.
- psum_valid_P2M  in  1  PE has a psum on psum_data_P2M.
- psum_ready_M2P  out  1  collector accepts the psum this cycle.
- out_data  out  DATA_WIDTH  FIFO head.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  out_data is the final psum of the tile.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at tile completion.
- drop_err  out  1  one-cycle pulse; a psum was offered while no tile was open.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset: rst is sampled on the rising edge of clk.
  - State returns to IDLE and the FIFO is flushed (pointers and level cleared).
  - All counters clear.
  - All outputs are 0: psum_ready_M2P, out_valid, out_last, out_data, busy, done, drop_err, fifo_level.
  - A reset mid-tile abandons the tile. No done pulse is produced.
- FSM has four states: IDLE, COLLECT, DRAIN, DONE.
  - IDLE -> COLLECT on start && tile_len != 0. Load remaining = tile_len. A start with tile_len == 0 is ignored.
  - COLLECT -> DRAIN on the edge where the final psum is accepted (remaining == 1 && accept).
  - DRAIN -> DONE on the edge where the out_last entry is handshaken (out_valid && out_ready && out_last).
  - DONE -> IDLE unconditionally. done = 1 only while in DONE.
  - start is ignored in every state except IDLE.
- Input handshake:
  - psum_ready_M2P = (state == COLLECT) && (fifo_level < FIFO_DEPTH). This is combinational from registered state.
  - accept = psum_valid_P2M && psum_ready_M2P. On accept, the psum is written at the tail and remaining decrements.
  - The PE must hold data and valid until accepted.
  - Each FIFO entry stores a last bit, set when remaining == 1 at the time of write.
- Output:
  - First-word fall-through: out_valid = (fifo_level != 0).
  - out_data and out_last show the head entry when out_valid = 1, and are forced to 0 when out_valid = 0.
  - Pop on out_valid && out_ready.
- Latency: a psum accepted at edge N is visible on out_data/out_valid after edge N, i.e. one cycle, when the FIFO was empty.
- Simultaneous push and pop with level not at FIFO_DEPTH: level is unchanged and both pointers advance.
- At full, ready is low, so there is no pass-through push. A pop at full reopens ready on the next cycle.
- Pointers wrap modulo FIFO_DEPTH.
- drop_err is registered and pulses the cycle after psum_valid_P2M = 1 is seen in IDLE. Psums in IDLE are never stored.
- In DRAIN and DONE, psum_valid_P2M is held off with ready = 0 and does not raise drop_err.
- No arithmetic is applied to data apart from the optional feature.

Optional Feature:
- Macro: PSUM_RELU_EN.
- Defined: on write into the FIFO, negative psums (MSB = 1) are stored as 0; non-negative values pass unchanged. This adds no latency.
- Undefined: psums are stored bit-exact.

Test Plan:
- Reset: hold rst for 3 cycles with random inputs -> all outputs 0, fifo_level 0, psum_ready_M2P 0.
- Basic tile: start with tile_len = 4; psums 0x0001, 0x0002, 0x0003, 0x0004 back-to-back; out_ready = 1.
  - Output is 1, 2, 3, 4, each one cycle after acceptance.
  - out_last is high only with 0x0004.
  - done pulses one cycle after the last handshake; busy drops on the following cycle.
- Backpressure and wrap: out_ready = 0, tile_len = 12, PE streaming.
  - Exactly 8 psums are accepted; fifo_level = 8; psum_ready_M2P goes low.
  - Release out_ready -> all 12 values exit in order, with the pointer wrap exercised.
  - The PE stalls are observed while the FIFO is full.
- Idle drop: psum_valid_P2M = 1 with data 0x00AA while in IDLE.
  - drop_err pulses the next cycle; fifo_level stays 0; out_valid stays 0.
  - start with tile_len = 0 -> busy stays 0.
- Reset mid-op: tile_len = 6, accept 3 psums, out_ready = 0, then pulse rst.
  - Next cycle: IDLE, fifo_level 0, out_valid 0, no done.
  - A new tile with tile_len = 2 then completes normally.
- Feature check: feed psum 0xFFFB (-5) and 0x0007.
  - With PSUM_RELU_EN defined: outputs 0x0000 and 0x0007.
  - Without it: outputs 0xFFFB and 0x0007.
